spi_slave_ctrl: RTL
===================

// Module: spi_slave_ctrl
// PURPOSE
// Parametrised SPI peripheral-side controller. Deserialises MOSI into an
// ADDR_W-bit address, an R/W bit and DATA_W-bit frames, and drives a
// synchronous memory port. On reads it serialises memory data onto MISO.
// Sits between the input conditioner (sclk edges, cs_n, mosi) and the data memory.
// PARAMETERS
// ADDR_W   7   address bits per command, MSB first
// DATA_W   8   data bits per frame, MSB first
// PORTS
// clk          in   1       system clock; all logic on posedge
// rst_n        in   1       asynchronous reset, active low
// sclk_pos     in   1       1-clk pulse per conditioned SCLK rising edge
// sclk_neg     in   1       1-clk pulse per conditioned SCLK falling edge
// cs_n         in   1       conditioned chip select, active low
// mosi         in   1       conditioned serial data in
// miso         out  1       serial data out
// miso_oe      out  1       MISO tri-state enable; 1 only in a read data phase
// mem_addr     out  ADDR_W  registered memory address
// mem_wdata    out  DATA_W  registered write data
// mem_we       out  1       1-clk write strobe
// mem_re       out  1       1-clk read strobe; mem_rdata valid on the next clk
// mem_rdata    in   DATA_W  memory read data
// busy         out  1       high from cs_n fall to return to IDLE
// abort        out  1       1-clk pulse when cs_n rises with a frame partly received
// BEHAVIOUR
// - Reset: every output is 0, the state is IDLE, and all counters and shift registers are cleared.
// - States: IDLE, CMD, FETCH, DATA, HOLD.
// - IDLE -> CMD on the first clk with cs_n=0. The bit counter clears and busy=1.
// - CMD: mosi is sampled on each sclk_pos. After ADDR_W+1 samples:
//   - mem_addr takes the first ADDR_W bits. The last bit is rw (1=read, 0=write).
//   - rw=0 -> DATA. rw=1 -> FETCH.
// - FETCH: mem_re=1 for one clk. On the next clk, mem_rdata loads the tx shift register,
//   miso=tx MSB, miso_oe=1, then -> DATA.
// - DATA, write: DATA_W samples on sclk_pos fill the rx shift register. On the clk after
//   the last sample, mem_wdata=rx and mem_we=1 for one clk at the current mem_addr.
// - DATA, read: the tx register shifts on each sclk_neg, and miso=next bit. Bits are sampled
//   by the master on sclk_pos, so the MSB is valid before the first data sclk_pos.
// - After DATA_W bits: behaviour per CONFIGURATION.
// - HOLD: all sclk pulses are ignored, miso_oe=0, and nothing is written.
// - Any state with cs_n=1 -> IDLE on the next clk:
//   - busy=0, miso_oe=0, counters cleared.
//   - A partial write frame is discarded, with no mem_we.
//   - abort=1 for one clk if 0 < bit count < frame length.
// - Simultaneous events:
//   - cs_n=1 and sclk_pos in the same clk: cs_n wins and the bit is not sampled.
//   - sclk_pos and sclk_neg in the same clk: sclk_pos is processed first.
// - Timing constraint: the SCLK half-period is at least 3 clk, which leaves room for FETCH.
// - mem_addr holds its value after IDLE until the next command completes.
// - mem_wdata is only meaningful during mem_we.
// CONFIGURATION
// SPI_BURST_EN defined:
// - After each full data frame, mem_addr increments by 1 and wraps from 2^ADDR_W-1 to 0.
// - The state stays in DATA for the next frame.
// - A write frame raises mem_we before the increment takes effect.
// - A read frame issues mem_re for the new address on the clk after the increment,
//   and reloads tx before the next sclk_neg.
// SPI_BURST_EN undefined:
// - After one data frame, DATA -> HOLD until cs_n rises. mem_addr never increments.
// TESTING
// 1. Write (defaults): cmd 0x2A,rw=0; data 0xC5 -> one mem_we, mem_addr=0x2A, mem_wdata=0xC5.
// 2. Read: mem[0x13]=0x9E; cmd 0x13,rw=1 -> one mem_re, MISO bits 1,0,0,1,1,1,1,0, miso_oe=1 for 8 bits only.
// 3. Abort: cs_n rises after 4 of 8 data bits of a write -> abort pulse, no mem_we, busy=0 next clk.
// 4. Burst (SPI_BURST_EN): write at 0x7F with 3 frames 0x11,0x22,0x33 -> mem_we at 0x7F,0x00,0x01.
// 5. No burst: same stimulus as 4 with macro undefined -> single mem_we (0x7F,0x11), then HOLD until cs_n=1.
// 6. Reset mid-read (rst_n=0 during DATA) -> all outputs 0 immediately, IDLE after release.
// 7. Params ADDR_W=10, DATA_W=16: read of 0x3FF returns 0xBEEF MSB first on MISO.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI peripheral-side controller: command/address deserialiser and memory port driver.
// Optional build macro SPI_BURST_EN enables auto-incrementing multi-frame bursts.
module spi_slave_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_pos,
  input  logic              sclk_neg,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              abort
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam int MAXF = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CW   = $clog2(MAXF + 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(ADDR_W);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  logic [2:0]        state;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              data_end;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic              rw;
  logic              ld_pend;
  logic              inc_pend;

  assign miso = miso_oe & tx_sr[DATA_W-1];

  // Count after any sclk_pos in this clk, so a coincident sclk_neg sees the updated count.
  always_comb begin
    data_end = sclk_pos && (bit_cnt == DATA_LAST);
    cnt_nxt  = bit_cnt;
    if (sclk_pos) cnt_nxt = data_end ? '0 : bit_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      addr_sr   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rw        <= 1'b0;
      ld_pend   <= 1'b0;
      inc_pend  <= 1'b0;
      miso_oe   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      abort   <= 1'b0;
      // Read data is valid the clk after the strobe; load tx one clk later.
      ld_pend <= mem_re;
      if (cs_n) begin
        abort    <= (state == S_CMD || state == S_DATA) && (bit_cnt != '0);
        state    <= S_IDLE;
        busy     <= 1'b0;
        miso_oe  <= 1'b0;
        bit_cnt  <= '0;
        rx_sr    <= '0;
        tx_sr    <= '0;
        ld_pend  <= 1'b0;
        inc_pend <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_CMD;
            busy    <= 1'b1;
            bit_cnt <= '0;
            addr_sr <= '0;
          end
          S_CMD: begin
            if (sclk_pos) begin
              if (bit_cnt == CMD_LAST) begin
                mem_addr <= addr_sr;
                rw       <= mosi;
                bit_cnt  <= '0;
                if (mosi) begin
                  state  <= S_FETCH;
                  mem_re <= 1'b1;
                end else begin
                  state  <= S_DATA;
                end
              end else begin
                addr_sr <= {addr_sr[ADDR_W-2:0], mosi};
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
          S_FETCH: begin
            if (ld_pend) begin
              tx_sr   <= mem_rdata;
              miso_oe <= 1'b1;
              state   <= S_DATA;
            end
          end
          S_DATA: begin
            if (inc_pend) begin
              inc_pend <= 1'b0;
              mem_addr <= mem_addr + ADDR_W'(1);
              if (rw) mem_re <= 1'b1;
            end
            if (ld_pend) tx_sr <= mem_rdata;
            bit_cnt <= cnt_nxt;
            if (sclk_pos && !rw) rx_sr <= {rx_sr[DATA_W-2:0], mosi};
            if (data_end) begin
              if (!rw) begin
                mem_we    <= 1'b1;
                mem_wdata <= {rx_sr[DATA_W-2:0], mosi};
              end
`ifdef SPI_BURST_EN
              inc_pend <= 1'b1;
`else
              state    <= S_HOLD;
              miso_oe  <= 1'b0;
`endif
            end
            // The trailing falling edge of a frame (count back at 0) must not disturb the MSB.
            if (sclk_neg && rw && cnt_nxt != '0) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
          end
          S_HOLD: begin
            miso_oe <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
